// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master packet shifter.
// Holds the transaction state encoding and the idle levels of the SPI bus.
package spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_IDLE   = 1'b1;

  // Chip select is asserted for the whole SETUP..HOLD frame
  function automatic logic is_framed(input state_t s);
    return (s == SETUP) || (s == XFER) || (s == HOLD);
  endfunction

endpackage

// File: rtl/spi_sclk_divider.sv
// SCLK half-period timer: down-counter that pulses half_tick for one cycle
// whenever it reaches zero while enabled, then reloads.
module spi_sclk_divider #(
  parameter int clk_div = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic half_tick
);

  localparam int CW = $clog2(clk_div + 1);
  localparam logic [CW-1:0] RELOAD = CW'(clk_div - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic [CW-1:0] div_cnt_r;

  // Half-period down-counter with reload on restart or on reaching zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_r <= '0;
    end else if (restart) begin
      div_cnt_r <= RELOAD;
    end else if (enable) begin
      if (div_cnt_r == '0) begin
        div_cnt_r <= RELOAD;
      end else begin
        div_cnt_r <= div_cnt_r - ONE;
      end
    end else begin
      div_cnt_r <= div_cnt_r;
    end
  end

  assign half_tick = enable && (div_cnt_r == '0);

endmodule

// File: rtl/spi_master_packet_shifter.sv
// SPI mode-0 master: takes one packet per val/rdy request, shifts it MSB-first
// in a chip-select frame and returns the word captured on MISO.
module spi_master_packet_shifter
  import spi_master_pkg::*;
#(
  parameter int nbits   = 8,
  parameter int clk_div = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             recv_val,
  output logic             recv_rdy,
  input  logic [nbits-1:0] recv_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic [nbits-1:0] send_msg,
  output logic             spi_sclk,
  output logic             spi_cs_n,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int BW = (nbits > 2) ? $clog2(nbits) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(nbits - 1);
  localparam logic [BW-1:0] ONE      = BW'(1);

  state_t           state_r;
  state_t           state_next_s;
  logic [nbits-1:0] sr_r;
  logic [BW-1:0]    bit_cnt_r;
  logic             rx_bit_r;
  logic             sclk_r;
  logic             cs_n_r;
  logic             recv_rdy_r;
  logic             send_val_r;
  logic             accept_s;
  logic             div_en_s;
  logic             half_tick_s;
  logic             last_fall_s;

  assign accept_s    = recv_val && (state_r == IDLE);
  assign div_en_s    = is_framed(state_r);
  assign last_fall_s = (state_r == XFER) && half_tick_s && sclk_r && (bit_cnt_r == LAST_BIT);

  spi_sclk_divider #(
    .clk_div (clk_div)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .enable    (div_en_s),
    .restart   (accept_s),
    .half_tick (half_tick_s)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; HOLD reuses the divider so it lasts exactly one half-period
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (recv_val) state_next_s = SETUP;
        else          state_next_s = IDLE;
      end
      SETUP: begin
        if (half_tick_s) state_next_s = XFER;
        else             state_next_s = SETUP;
      end
      XFER: begin
        if (last_fall_s) state_next_s = HOLD;
        else             state_next_s = XFER;
      end
      HOLD: begin
        if (half_tick_s) state_next_s = DONE;
        else             state_next_s = HOLD;
      end
      DONE: begin
        if (send_rdy) state_next_s = IDLE;
        else          state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Handshake and chip-select outputs, registered from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      recv_rdy_r <= 1'b1;
      send_val_r <= 1'b0;
      cs_n_r     <= CS_IDLE;
    end else begin
      recv_rdy_r <= (state_next_s == IDLE);
      send_val_r <= (state_next_s == DONE);
      cs_n_r     <= is_framed(state_next_s) ? ~CS_IDLE : CS_IDLE;
    end
  end

  // Shift datapath: sample MISO on rising SCLK, shift it in on falling SCLK
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_r      <= '0;
      bit_cnt_r <= '0;
      rx_bit_r  <= 1'b0;
      sclk_r    <= SCLK_IDLE;
    end else if (accept_s) begin
      sr_r      <= recv_msg;
      bit_cnt_r <= '0;
      rx_bit_r  <= rx_bit_r;
      sclk_r    <= SCLK_IDLE;
    end else if ((state_r == XFER) && half_tick_s) begin
      sclk_r <= ~sclk_r;
      if (!sclk_r) begin
        rx_bit_r <= spi_miso;
      end else begin
        sr_r <= {sr_r[nbits-2:0], rx_bit_r};
        if (bit_cnt_r != LAST_BIT) bit_cnt_r <= bit_cnt_r + ONE;
        else                       bit_cnt_r <= bit_cnt_r;
      end
    end else begin
      sr_r      <= sr_r;
      bit_cnt_r <= bit_cnt_r;
      rx_bit_r  <= rx_bit_r;
      sclk_r    <= sclk_r;
    end
  end

  assign recv_rdy = recv_rdy_r;
  assign send_val = send_val_r;
  assign send_msg = sr_r;
  assign spi_sclk = sclk_r;
  assign spi_cs_n = cs_n_r;
  assign spi_mosi = sr_r[nbits-1];

endmodule

// File: tb/tb_spi_master_packet_shifter.sv
// Scoreboard bench for spi_master_packet_shifter: three configurations
// (8b/div2 main, 8b/div1 and 16b/div3 loopback latency checks).
module tb_spi_master_packet_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic reset = 1'b1;

  // main instance: nbits=8, clk_div=2
  logic       recv_val0 = 1'b0, recv_rdy0, send_val0, send_rdy0 = 1'b1;
  logic       sclk0, cs_n0, mosi0, miso0;
  logic [7:0] recv_msg0 = 8'h00, send_msg0;
  logic       loop0 = 1'b1, model_bit0 = 1'b0;
  logic [7:0] pat0 = 8'h00;

  // nbits=8, clk_div=1 loopback
  logic       recv_val1 = 1'b0, recv_rdy1, send_val1, sclk1, cs_n1, mosi1;
  logic [7:0] recv_msg1 = 8'h00, send_msg1;

  // nbits=16, clk_div=3 loopback
  logic        recv_val2 = 1'b0, recv_rdy2, send_val2, sclk2, cs_n2, mosi2;
  logic [15:0] recv_msg2 = 16'h0000, send_msg2;

  assign miso0 = loop0 ? mosi0 : model_bit0;

  spi_master_packet_shifter #(.nbits(8), .clk_div(2)) dut (
    .clk(clk), .reset(reset), .recv_val(recv_val0), .recv_rdy(recv_rdy0), .recv_msg(recv_msg0),
    .send_val(send_val0), .send_rdy(send_rdy0), .send_msg(send_msg0),
    .spi_sclk(sclk0), .spi_cs_n(cs_n0), .spi_mosi(mosi0), .spi_miso(miso0));

  spi_master_packet_shifter #(.nbits(8), .clk_div(1)) dut1 (
    .clk(clk), .reset(reset), .recv_val(recv_val1), .recv_rdy(recv_rdy1), .recv_msg(recv_msg1),
    .send_val(send_val1), .send_rdy(1'b1), .send_msg(send_msg1),
    .spi_sclk(sclk1), .spi_cs_n(cs_n1), .spi_mosi(mosi1), .spi_miso(mosi1));

  spi_master_packet_shifter #(.nbits(16), .clk_div(3)) dut2 (
    .clk(clk), .reset(reset), .recv_val(recv_val2), .recv_rdy(recv_rdy2), .recv_msg(recv_msg2),
    .send_val(send_val2), .send_rdy(1'b1), .send_msg(send_msg2),
    .spi_sclk(sclk2), .spi_cs_n(cs_n2), .spi_mosi(mosi2), .spi_miso(mosi2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- main instance: bus model and frame statistics
  logic sclk0_q = 1'b0, cs_n0_q = 1'b1, mosi_all0 = 1'b1;
  int   rise0 = 0, hi0 = 0, frames0 = 0;
  always @(negedge clk) begin
    if (!cs_n0 && cs_n0_q) begin
      rise0 = 0; hi0 = 0; mosi_all0 = 1'b1; frames0++;
    end
    if (!cs_n0) begin
      if (sclk0 && !sclk0_q) begin
        rise0++;
        mosi_all0 = mosi_all0 & mosi0;
      end
      if (sclk0) hi0++;
    end
    sclk0_q = sclk0;
    cs_n0_q = cs_n0;
    model_bit0 = (rise0 < 8) ? pat0[3'(7 - rise0)] : 1'b0;
  end

  // ---------------- main instance scoreboard monitor
  logic [7:0] exp0_q[$];
  int   acc0 = 0;
  logic sv0_q = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      if (recv_val0 && recv_rdy0) acc0 = cyc;
      if (send_val0 && !sv0_q) chk("lat0", cyc - acc0, 37);
      if (send_val0 && send_rdy0) begin
        if (exp0_q.size() == 0) chk("unexpected0", {24'd0, send_msg0}, 32'hFFFF_FFFF);
        else chk("data0", {24'd0, send_msg0}, {24'd0, exp0_q.pop_front()});
      end
    end
    sv0_q = send_val0;
  end

  // ---------------- secondary instance monitors
  logic [7:0]  exp1_q[$];
  logic [15:0] exp2_q[$];
  int   acc1 = 0, acc2 = 0, rise1 = 0, rise2 = 0;
  logic sv1_q = 1'b0, sv2_q = 1'b0, sclk1_q = 1'b0, sclk2_q = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      if (recv_val1 && recv_rdy1) begin acc1 = cyc; rise1 = 0; end
      if (!cs_n1 && sclk1 && !sclk1_q) rise1++;
      if (send_val1 && !sv1_q) begin
        chk("lat1", cyc - acc1, 19);
        chk("rise1", rise1, 8);
        if (exp1_q.size() == 0) chk("unexpected1", {24'd0, send_msg1}, 32'hFFFF_FFFF);
        else chk("data1", {24'd0, send_msg1}, {24'd0, exp1_q.pop_front()});
      end
      if (recv_val2 && recv_rdy2) begin acc2 = cyc; rise2 = 0; end
      if (!cs_n2 && sclk2 && !sclk2_q) rise2++;
      if (send_val2 && !sv2_q) begin
        chk("lat2", cyc - acc2, 103);
        chk("rise2", rise2, 16);
        if (exp2_q.size() == 0) chk("unexpected2", {16'd0, send_msg2}, 32'hFFFF_FFFF);
        else chk("data2", {16'd0, send_msg2}, {16'd0, exp2_q.pop_front()});
      end
    end
    sv1_q = send_val1; sclk1_q = sclk1;
    sv2_q = send_val2; sclk2_q = sclk2;
  end

  task automatic send0(input logic [7:0] d, input logic [7:0] e);
    int n = 0;
    recv_msg0 = d;
    recv_val0 = 1'b1;
    exp0_q.push_back(e);
    while (!recv_rdy0 && n < 300) begin step(); n++; end
    chk("accept_wait0", recv_rdy0, 1);
    step();
    recv_val0 = 1'b0;
  endtask

  task automatic wait_idle0(input string name);
    int n = 0;
    while (!(recv_rdy0 && exp0_q.size() == 0) && n < 300) begin step(); n++; end
    chk(name, (n < 300) ? 1 : 0, 1);
  endtask

  initial begin
    int n, a0, a1, a2, f0;
    #2 reset = 1'b0;
    #3;
    chk("rst_recv_rdy", recv_rdy0, 1);
    chk("rst_send_val", send_val0, 0);
    chk("rst_send_msg", send_msg0, 0);
    chk("rst_sclk", sclk0, 0);
    chk("rst_cs_n", cs_n0, 1);
    chk("rst_mosi", mosi0, 0);
    step();
    reset = 1'b1;

    // MISO model returns 0x3C while sending 0xFF
    loop0 = 1'b0; pat0 = 8'h3C;
    send0(8'hFF, 8'h3C);
    wait_idle0("idle_a");
    chk("rise_a", rise0, 8);
    chk("mosi_high_a", mosi_all0, 1);
    chk("sclk_high_cycles_a", hi0, 16);
    loop0 = 1'b1;

    // back-pressure in DONE; a request during DONE must be ignored
    send_rdy0 = 1'b0;
    send0(8'h5A, 8'h5A);
    n = 0;
    while (!send_val0 && n < 200) begin step(); n++; end
    chk("bp_reach_done", send_val0, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin recv_msg0 = 8'hEE; recv_val0 = 1'b1; end
      else recv_val0 = 1'b0;
      chk("bp_send_val", send_val0, 1);
      chk("bp_send_msg", {24'd0, send_msg0}, 32'h5A);
      chk("bp_recv_rdy", recv_rdy0, 0);
      step();
    end
    recv_val0 = 1'b0;
    send_rdy0 = 1'b1;
    wait_idle0("idle_bp");

    // reset in XFER after 3 bits of 0xC3
    send0(8'hC3, 8'hC3);
    repeat (15) step();
    chk("mid_cs_n", cs_n0, 0);
    #2 reset = 1'b0;
    #1;
    chk("abort_cs_n", cs_n0, 1);
    chk("abort_sclk", sclk0, 0);
    chk("abort_send_val", send_val0, 0);
    exp0_q.delete();
    step();
    reset = 1'b1;
    send0(8'h81, 8'h81);
    wait_idle0("idle_after_rst");

    // back-to-back requests
    f0 = frames0;
    send0(8'h12, 8'h12); a0 = cyc;
    send0(8'h34, 8'h34); a1 = cyc;
    send0(8'h56, 8'h56); a2 = cyc;
    wait_idle0("idle_b2b");
    chk("b2b_space1", a1 - a0, 38);
    chk("b2b_space2", a2 - a1, 38);
    chk("b2b_frames", frames0 - f0, 3);

    // nbits=8, clk_div=1 loopback 0xA5
    recv_msg1 = 8'hA5; recv_val1 = 1'b1; exp1_q.push_back(8'hA5);
    step();
    recv_val1 = 1'b0;
    n = 0;
    while (!(recv_rdy1 && exp1_q.size() == 0) && n < 100) begin step(); n++; end
    chk("idle1", (n < 100) ? 1 : 0, 1);

    // nbits=16, clk_div=3 loopback 0xBEEF
    recv_msg2 = 16'hBEEF; recv_val2 = 1'b1; exp2_q.push_back(16'hBEEF);
    step();
    recv_val2 = 1'b0;
    n = 0;
    while (!(recv_rdy2 && exp2_q.size() == 0) && n < 300) begin step(); n++; end
    chk("idle2", (n < 300) ? 1 : 0, 1);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
